// File: rtl/jpeg_wb_arbiter_if.sv
// Classic 32-bit Wishbone point-to-point bundle used between the arbiter,
// its two masters and the shared slave.
interface jpeg_wb_arbiter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;  // master -> slave write data
  logic [31:0] dat_r;  // slave -> master read data
  logic        ack;
  logic        err;

  // Seen from the side that drives the request.
  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, err
  );

  // Seen from the side that answers the request.
  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, err
  );
endinterface

// File: rtl/jpeg_wb_arbiter.sv
// Two-master / one-slave Wishbone arbiter for the JPEG block.
// m0 is the DMA read master, m1 the CPU data master. Ownership alternates
// round-robin; an owner that holds the bus for MAX_HOLD cycles while the other
// master waits is preempted at the next transfer boundary, through one dead
// SWITCH cycle. A response watchdog turns a slave that never answers into an
// err to the current owner.
module jpeg_wb_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  jpeg_wb_arbiter_if.slave  m0,
  jpeg_wb_arbiter_if.slave  m1,
  jpeg_wb_arbiter_if.master s,
  output logic [1:0]        gnt_o,
  output logic              timeout_o
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_0  = 2'd1,
    OWN_1  = 2'd2,
    SWITCH = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              last_reg, last_next;   // most recent owner, loses the next tie
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;

  logic own_active;
  logic slave_done;
  logic stb_wait;
  logic wd_fire;
  logic own_done;
  logic hold_full;

  assign own_active = (state_reg == OWN_0) || (state_reg == OWN_1);
  // s.stb is already 0 outside OWN, so slave responses in IDLE/SWITCH never
  // reach the watchdog or a master.
  assign slave_done = s.ack | s.err;
  assign stb_wait   = s.stb & ~slave_done;
  // A real ack/err on the expiry cycle suppresses the forced error.
  assign wd_fire    = (TIMEOUT != 0) && stb_wait && (wait_cnt_reg == WAIT_LAST);
  assign own_done   = slave_done | wd_fire;
  // hold_cnt saturates at HOLD_LAST, so equality means "limit reached".
  assign hold_full  = (hold_cnt_reg == HOLD_LAST);

  // Read data is broadcast; only ack/err qualify it per master.
  assign m0.dat_r  = s.dat_r;
  assign m1.dat_r  = s.dat_r;
  assign gnt_o     = {state_reg == OWN_1, state_reg == OWN_0};
  assign timeout_o = wd_fire;

  // Forward the owner's request to the slave; nothing is forwarded in IDLE/SWITCH.
  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.sel   = 4'h0;
    s.adr   = 32'h0;
    s.dat_w = 32'h0;
    case (state_reg)
      OWN_0: begin
        s.cyc   = m0.cyc;
        s.stb   = m0.stb;
        s.we    = m0.we;
        s.sel   = m0.sel;
        s.adr   = m0.adr;
        s.dat_w = m0.dat_w;
      end
      OWN_1: begin
        s.cyc   = m1.cyc;
        s.stb   = m1.stb;
        s.we    = m1.we;
        s.sel   = m1.sel;
        s.adr   = m1.adr;
        s.dat_w = m1.dat_w;
      end
      default: ;
    endcase
  end

  // Route slave responses (and the forced watchdog err) to the owner only.
  always_comb begin
    m0.ack = 1'b0;
    m0.err = 1'b0;
    m1.ack = 1'b0;
    m1.err = 1'b0;
    case (state_reg)
      OWN_0: begin
        m0.ack = s.ack;
        m0.err = s.err | wd_fire;
      end
      OWN_1: begin
        m1.ack = s.ack;
        m1.err = s.err | wd_fire;
      end
      default: ;
    endcase
  end

  // Ownership FSM: round-robin grant, hold-limit preemption at transfer boundaries.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (m0.cyc && m1.cyc)
          state_next = last_reg ? OWN_0 : OWN_1;
        else if (m0.cyc)
          state_next = OWN_0;
        else if (m1.cyc)
          state_next = OWN_1;
      end
      OWN_0: begin
        if (!m0.cyc)
          state_next = IDLE;
        else if (hold_full && m1.cyc && own_done)
          state_next = SWITCH;
      end
      OWN_1: begin
        if (!m1.cyc)
          state_next = IDLE;
        else if (hold_full && m0.cyc && own_done)
          state_next = SWITCH;
      end
      // The waiting master is granted even if it has since dropped cyc;
      // its OWN state then falls back to IDLE on the next cycle.
      SWITCH: state_next = last_reg ? OWN_0 : OWN_1;
      default: state_next = IDLE;
    endcase
    if ((state_next == OWN_0) && (state_reg != OWN_0))
      last_next = 1'b0;
    else if ((state_next == OWN_1) && (state_reg != OWN_1))
      last_next = 1'b1;
  end

  // Hold and watchdog counters; both restart whenever the state changes.
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    if (state_next != state_reg)
      hold_cnt_next = '0;
    else if (own_active && !hold_full)
      hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
    if (!stb_wait || wd_fire || (state_next != state_reg))
      wait_cnt_next = '0;
    else
      wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
  end

  // State registers; reset releases the bus immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      hold_cnt_reg <= '0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      hold_cnt_reg <= hold_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

endmodule

// File: tb/tb_jpeg_wb_arbiter.sv
// Self-checking bench for jpeg_wb_arbiter: a table of single-cycle vectors
// for grant/routing, then hand-written sequences for latency, preemption,
// watchdog and asynchronous reset. Read data is checked through per-master
// scoreboard queues filled when a transfer is issued.
module tb_jpeg_wb_arbiter;

  localparam logic [31:0] DKEY = 32'h5A5A_1234;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [1:0] gnt_o;
  logic timeout_o;

  jpeg_wb_arbiter_if m0_bus ();
  jpeg_wb_arbiter_if m1_bus ();
  jpeg_wb_arbiter_if s_bus ();

  jpeg_wb_arbiter #(.MAX_HOLD(16), .TIMEOUT(64)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .gnt_o     (gnt_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Slave model: automatic ack after slave_lat wait cycles, or manual ack/err.
  logic slave_auto = 1'b0;
  int   slave_lat  = 0;
  logic ack_force  = 1'b0;
  logic err_force  = 1'b0;
  int   slv_cnt    = 0;

  assign s_bus.ack   = slave_auto ? (s_bus.stb && (slv_cnt == slave_lat)) : ack_force;
  assign s_bus.err   = slave_auto ? 1'b0 : err_force;
  assign s_bus.dat_r = s_bus.adr ^ DKEY;

  always @(posedge clk_i) begin
    if (!s_bus.stb || s_bus.ack) slv_cnt <= 0;
    else                         slv_cnt <= slv_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bench master state and scoreboards.
  int          m_left[2];
  logic [31:0] m_addr[2];
  logic        m_new[2];
  int          m_ack_cnt[2];
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic drive_masters();
    if (m_left[0] > 0 && m_new[0]) begin q0.push_back(m_addr[0] ^ DKEY); m_new[0] = 1'b0; end
    if (m_left[1] > 0 && m_new[1]) begin q1.push_back(m_addr[1] ^ DKEY); m_new[1] = 1'b0; end
    m0_bus.cyc = (m_left[0] > 0); m0_bus.stb = (m_left[0] > 0); m0_bus.we = 1'b0;
    m0_bus.sel = 4'hF; m0_bus.adr = m_addr[0]; m0_bus.dat_w = 32'h0;
    m1_bus.cyc = (m_left[1] > 0); m1_bus.stb = (m_left[1] > 0); m1_bus.we = 1'b0;
    m1_bus.sel = 4'hF; m1_bus.adr = m_addr[1]; m1_bus.dat_w = 32'h0;
  endtask

  task automatic observe_acks();
    logic [31:0] exp_d;
    if (m0_bus.ack) begin
      m_ack_cnt[0]++;
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL m0_sb: ack with nothing outstanding, got ack=1 expected ack=0");
      end else begin
        exp_d = q0.pop_front();
        check("m0_rdata", 64'(m0_bus.dat_r), 64'(exp_d));
        $display("m0 read adr=%08h data=%08h", m_addr[0], m0_bus.dat_r);
      end
      m_left[0]--; m_addr[0] += 32'd4; m_new[0] = 1'b1;
    end
    if (m1_bus.ack) begin
      m_ack_cnt[1]++;
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL m1_sb: ack with nothing outstanding, got ack=1 expected ack=0");
      end else begin
        exp_d = q1.pop_front();
        check("m1_rdata", 64'(m1_bus.dat_r), 64'(exp_d));
        $display("m1 read adr=%08h data=%08h", m_addr[1], m1_bus.dat_r);
      end
      m_left[1]--; m_addr[1] += 32'd4; m_new[1] = 1'b1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Reset with all inputs idle; returns just after an active edge, rst released.
  task automatic do_reset();
    rst_i = 1'b1;
    slave_auto = 1'b0; slave_lat = 0; ack_force = 1'b0; err_force = 1'b0;
    m_left[0] = 0; m_left[1] = 0; m_new[0] = 1'b1; m_new[1] = 1'b1;
    m_addr[0] = 32'h0000_1000; m_addr[1] = 32'h0000_8000;
    m_ack_cnt[0] = 0; m_ack_cnt[1] = 0;
    q0.delete(); q1.delete();
    drive_masters();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  typedef struct packed {
    logic       m0;
    logic       m1;
    logic       ack;
    logic       err;
    logic [1:0] gnt;
    logic       scyc;
    logic [3:0] resp;   // {m0_ack, m0_err, m1_ack, m1_err}
  } vec_t;

  vec_t vecs[17];
  logic [1:0] exp_gnt2[9];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench time limit");
  end

  initial begin
    int first_ack, m1_ack_seen, sw_cyc, pre_acks, bad_acks, fire_cyc, fires, m0_err_seen, m1_err_cnt;

    //            m0    m1    ack   err   gnt    scyc  resp
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000};  // ack in IDLE ignored
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 4'b1000};  // tie went to m0
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 4'b0100};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 4'b0000};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'b0000};  // m0 drops cyc
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000};  // IDLE between
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 4'b0010};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 4'b0001};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 4'b0000};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 4'b1000};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'b0000};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 4'b0000};  // tie went to m1 (last=m0)
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 4'b0000};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000};
    exp_gnt2 = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};

    // Reset state: everything low, read data follows the slave.
    m_addr[0] = 32'h0; m_addr[1] = 32'h0; m_left[0] = 0; m_left[1] = 0;
    drive_masters();
    @(negedge clk_i);
    @(negedge clk_i);
    check("reset_outputs", 64'({gnt_o, timeout_o, s_bus.cyc, s_bus.stb, m0_bus.ack, m0_bus.err,
                                m1_bus.ack, m1_bus.err}), 64'(0));
    check("reset_dat_bcast", 64'({m0_bus.dat_r, m1_bus.dat_r}), 64'({DKEY, DKEY}));

    // Vector table: grant, tie-break and response routing cycle by cycle.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      m0_bus.cyc = vecs[i].m0; m0_bus.stb = vecs[i].m0;
      m1_bus.cyc = vecs[i].m1; m1_bus.stb = vecs[i].m1;
      ack_force = vecs[i].ack; err_force = vecs[i].err;
      @(negedge clk_i);
      check($sformatf("vec%0d", i),
            64'({gnt_o, s_bus.cyc, m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err}),
            64'({vecs[i].gnt, vecs[i].scyc, vecs[i].resp}));
      next_cycle();
    end

    // Test 1: m0 alone, slave acks on the third stb cycle.
    do_reset();
    slave_auto = 1'b1; slave_lat = 2; m_left[0] = 3;
    first_ack = -1; m1_ack_seen = 0;
    for (int c = 0; c < 20; c++) begin
      drive_masters();
      @(negedge clk_i);
      if (c == 0) check("t1_gnt_at_cyc", 64'(gnt_o), 64'(2'b00));
      if (c == 1) check("t1_gnt_latency", 64'(gnt_o), 64'(2'b01));
      if (gnt_o == 2'b01) check("t1_ack_mirror", 64'(m0_bus.ack), 64'(s_bus.ack));
      if (m0_bus.ack && first_ack < 0) first_ack = c;
      if (m1_bus.ack) m1_ack_seen = 1;
      observe_acks();
      next_cycle();
    end
    check("t1_first_ack_cycle", 64'(first_ack), 64'(3));
    check("t1_m0_acks", 64'(m_ack_cnt[0]), 64'(3));
    check("t1_m1_no_ack", 64'(m1_ack_seen), 64'(0));
    check("t1_sb_drained", 64'(q0.size()), 64'(0));

    // Test 2: simultaneous request after reset; m0 first, IDLE, then m1.
    do_reset();
    slave_auto = 1'b1; slave_lat = 0; m_left[0] = 2; m_left[1] = 2;
    for (int c = 0; c < 9; c++) begin
      drive_masters();
      @(negedge clk_i);
      check($sformatf("t2_gnt_c%0d", c), 64'(gnt_o), 64'(exp_gnt2[c]));
      observe_acks();
      next_cycle();
    end
    check("t2_acks", 64'({m_ack_cnt[0][7:0], m_ack_cnt[1][7:0]}), 64'({8'd2, 8'd2}));

    // Test 3: m0 streams 40 reads, m1 asks at cycle 3, hold limit forces a switch.
    do_reset();
    slave_auto = 1'b1; slave_lat = 0; m_left[0] = 40;
    sw_cyc = -1; pre_acks = 0; bad_acks = 0;
    for (int c = 0; c < 80; c++) begin
      if (c == 3) m_left[1] = 2;
      drive_masters();
      @(negedge clk_i);
      if (c >= 1 && sw_cyc < 0 && gnt_o == 2'b00) begin
        sw_cyc = c;
        check("t3_dead_cycle", 64'({s_bus.cyc, m0_bus.ack, m1_bus.ack}), 64'(0));
      end
      if (sw_cyc >= 0 && c == sw_cyc + 1) check("t3_m1_owns", 64'(gnt_o), 64'(2'b10));
      if (sw_cyc < 0 && m0_bus.ack) pre_acks++;
      if (m0_bus.ack && gnt_o != 2'b01) bad_acks++;
      observe_acks();
      next_cycle();
    end
    check("t3_switch_cycle", 64'(sw_cyc), 64'(17));
    check("t3_acks_before_switch", 64'(pre_acks), 64'(16));
    check("t3_m0_ack_not_owner", 64'(bad_acks), 64'(0));
    check("t3_total_acks", 64'({m_ack_cnt[0][7:0], m_ack_cnt[1][7:0]}), 64'({8'd40, 8'd2}));
    check("t3_sb_drained", 64'(q0.size() + q1.size()), 64'(0));

    // Test 4: slave never answers m1; watchdog on the 64th stb cycle.
    do_reset();
    m_left[1] = 1;
    fire_cyc = -1; fires = 0; m0_err_seen = 0; m1_err_cnt = 0;
    for (int c = 0; c < 70; c++) begin
      drive_masters();
      @(negedge clk_i);
      if (timeout_o) begin
        fires++;
        if (fire_cyc < 0) fire_cyc = c;
        check("t4_err_with_timeout", 64'(m1_bus.err), 64'(1));
      end
      if (m0_bus.err) m0_err_seen = 1;
      if (m1_bus.err) m1_err_cnt++;
      if (c == 65) check("t4_still_granted", 64'(gnt_o), 64'(2'b10));
      next_cycle();
    end
    check("t4_fire_cycle", 64'(fire_cyc), 64'(64));
    check("t4_single_pulse", 64'({fires[7:0], m1_err_cnt[7:0]}), 64'({8'd1, 8'd1}));
    check("t4_m0_no_err", 64'(m0_err_seen), 64'(0));

    // Test 5: ack lands on the expiry cycle and wins.
    do_reset();
    m_left[1] = 1;
    fires = 0;
    for (int c = 0; c < 70; c++) begin
      ack_force = (c == 64);
      drive_masters();
      @(negedge clk_i);
      if (timeout_o) fires++;
      if (c == 64) check("t5_ack_wins", 64'({m1_bus.ack, m1_bus.err, timeout_o}), 64'(3'b100));
      next_cycle();
    end
    ack_force = 1'b0;
    check("t5_no_timeout", 64'(fires), 64'(0));

    // Test 6: asynchronous reset in the middle of an acked transfer.
    do_reset();
    ack_force = 1'b1; m_left[0] = 5;
    drive_masters();
    next_cycle();
    drive_masters();
    @(negedge clk_i);
    check("t6_pre_reset", 64'({gnt_o, s_bus.cyc, m0_bus.ack}), 64'({2'b01, 1'b1, 1'b1}));
    #2;
    rst_i = 1'b1;
    m_left[1] = 5;
    drive_masters();
    #1;
    check("t6_async_release", 64'({gnt_o, s_bus.cyc, s_bus.stb, m0_bus.ack, m0_bus.err,
                                   m1_bus.ack, m1_bus.err}), 64'(0));
    ack_force = 1'b0;
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t6_idle_after_reset", 64'(gnt_o), 64'(2'b00));
    next_cycle();
    @(negedge clk_i);
    check("t6_first_grant_m0", 64'(gnt_o), 64'(2'b01));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
